alu_ctrl_seq: RTL
=================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter FUNCT_W, default 11: width of the funct opcode field.
REQ-002 SHALL have parameter MUL_LAT, default 4, legal range 2..16: total cycles occupied by one MUL, counted from its output handshake.
REQ-003 SHALL have parameter CNT_W, default 8: width of the illegal-opcode counter.
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid & in_ready.
- funct  in  FUNCT_W  opcode.
- aluop  in  2  00 mem, 01 CBZ, 10 R-type, 11 I-type.
- out_valid  out  1  decoded control present.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- alucontrol  out  4  decoded ALU control.
- illegal  out  1  decoded opcode unrecognised; qualified by out_valid.
- busy  out  1  multi-cycle MUL in progress.
- illegal_cnt  out  CNT_W  saturating count of illegal results handed off.

Function
REQ-006 Encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, PASS_B 0111, MUL 1000, LSL 1001, LSR 1010.
REQ-007 Decode rules:
- aluop 00 -> ADD.
- aluop 01 -> PASS_B.
- aluop 10 matches exact funct: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 OR, 10011011000 MUL.
- aluop 11 ignores funct[0]: 1001000100x ADD, 1101000100x SUB, 1001001000x AND, 1011001000x OR.
- Any other combination -> 0000 with illegal=1.
REQ-008 When FUNCT_W != 11, decoding SHALL use funct[FUNCT_W-1 -: 11]; lower bits are ignored.
REQ-009 FSM states:
- EMPTY: in_ready=1, out_valid=0.
- FULL: out_valid=1; in_ready=out_ready, unless the held op is MUL, in which case in_ready=0.
- MBUSY: in_ready=0, out_valid=0, busy=1.
REQ-010 An accept in EMPTY SHALL register the decoded result and move to FULL; latency is exactly 1 cycle.
REQ-011 A handshake in FULL of a non-MUL op together with a new accept SHALL stay in FULL with the new result (back-to-back, 1 op/cycle); a handshake with no accept SHALL go to EMPTY.
REQ-012 A handshake in FULL of a MUL op SHALL load the counter with MUL_LAT-1 and go to MBUSY.
REQ-013 MBUSY SHALL decrement the counter each cycle and go to EMPTY when it reads 1; MBUSY therefore lasts MUL_LAT-1 cycles.
REQ-014 alucontrol and illegal SHALL hold stable while out_valid=1 and out_ready=0; in_valid/funct changes in that window SHALL be ignored.
REQ-015 illegal_cnt SHALL increment on each output handshake with illegal=1 and saturate at all-ones.
REQ-016 busy SHALL be 1 only in MBUSY.

Reset
REQ-017 With reset=1 at a clock edge, the next-cycle state SHALL be: EMPTY, counter 0, alucontrol 0000, illegal 0, illegal_cnt 0, out_valid 0, busy 0.
REQ-018 Reset SHALL take priority over any simultaneous handshake; reset during MBUSY or FULL discards the in-flight op.
REQ-019 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-020 Macro ALUDEC_SHIFT_EN:
- Defined: aluop 10 additionally decodes 11010011011 -> LSL and 11010011010 -> LSR, both single-cycle.
- Undefined: these two opcodes are illegal (0000, illegal=1), and the 1001/1010 encodings never appear.

Verification
REQ-021 Reset, then aluop=10, funct=10001011000, in_valid=1, out_ready=1 -> next cycle out_valid=1, alucontrol=0010, illegal=0.
REQ-022 Four R-type ops on consecutive cycles (ADD, SUB, AND, ORR) with out_ready=1 -> 0010, 0110, 0000, 0001 on four consecutive cycles; in_ready stays 1.
REQ-023 MUL (10011011000) with MUL_LAT=4 and out_ready=1 -> out alucontrol=1000, then busy=1 and in_ready=0 for exactly 3 cycles, then in_ready=1.
REQ-024 Hold out_ready=0 for 5 cycles after ADDI (1001000100x) while toggling funct -> alucontrol stays 0010, in_ready=0, no new accept.
REQ-025 Send 300 illegal ops (aluop=10, funct=0) with CNT_W=8 -> illegal=1 and alucontrol=0000 on each; illegal_cnt saturates at 255.
REQ-026 Assert reset during MBUSY, then LSL with and without ALUDEC_SHIFT_EN -> after reset busy=0 and in_ready=1; LSL yields 1001 with the macro defined, 0000 with illegal=1 without it.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake and multi-cycle MUL occupancy.
// Optional macro ALUDEC_SHIFT_EN adds the LSL/LSR R-type decodes.
module alu_ctrl_seq #(
  parameter int unsigned FUNCT_W = 11,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [1:0]         aluop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         alucontrol,
  output logic               illegal,
  output logic               busy,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int unsigned OP_W  = 11;
  localparam int unsigned LAT_W = 5;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;
  localparam logic [3:0] ALU_MUL    = 4'b1000;
`ifdef ALUDEC_SHIFT_EN
  localparam logic [3:0] ALU_LSL    = 4'b1001;
  localparam logic [3:0] ALU_LSR    = 4'b1010;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_MBUSY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         alu_q, alu_d;
  logic               ill_q, ill_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;

  logic [OP_W-1:0]    op;
  logic [3:0]         dec_alu;
  logic               dec_ill;
  logic               held_mul;
  logic               accept;
  logic               handoff;

  // Only the top 11 funct bits take part in decoding.
  assign op = funct[FUNCT_W-1 -: OP_W];

  always_comb begin
    dec_alu = ALU_AND;
    dec_ill = 1'b0;
    case (aluop)
      2'b00: dec_alu = ALU_ADD;
      2'b01: dec_alu = ALU_PASS_B;
      2'b10: begin
        case (op)
          11'b10001011000: dec_alu = ALU_ADD;
          11'b11001011000: dec_alu = ALU_SUB;
          11'b10001010000: dec_alu = ALU_AND;
          11'b10101010000: dec_alu = ALU_OR;
          11'b10011011000: dec_alu = ALU_MUL;
`ifdef ALUDEC_SHIFT_EN
          11'b11010011011: dec_alu = ALU_LSL;
          11'b11010011010: dec_alu = ALU_LSR;
`endif
          default:         dec_ill = 1'b1;
        endcase
      end
      default: begin
        // I-type ignores the lowest opcode bit.
        case (op[OP_W-1:1])
          10'b1001000100: dec_alu = ALU_ADD;
          10'b1101000100: dec_alu = ALU_SUB;
          10'b1001001000: dec_alu = ALU_AND;
          10'b1011001000: dec_alu = ALU_OR;
          default:        dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign held_mul    = (alu_q == ALU_MUL);
  assign out_valid   = (state_q == S_FULL);
  assign busy        = (state_q == S_MBUSY);
  assign in_ready    = (state_q == S_EMPTY) ||
                       ((state_q == S_FULL) && out_ready && !held_mul);
  assign accept      = in_valid && in_ready;
  assign handoff     = out_valid && out_ready;
  assign alucontrol  = alu_q;
  assign illegal     = ill_q;
  assign illegal_cnt = icnt_q;

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    ill_d   = ill_q;
    lat_d   = lat_q;
    icnt_d  = icnt_q;
    if (handoff && ill_q && (icnt_q != {CNT_W{1'b1}})) begin
      icnt_d = icnt_q + CNT_W'(1);
    end
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          alu_d   = dec_alu;
          ill_d   = dec_ill;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (handoff) begin
          if (held_mul) begin
            lat_d   = LAT_W'(MUL_LAT - 1);
            state_d = S_MBUSY;
          end else if (accept) begin
            alu_d   = dec_alu;
            ill_d   = dec_ill;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      S_MBUSY: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      alu_q   <= 4'b0000;
      ill_q   <= 1'b0;
      lat_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      ill_q   <= ill_d;
      lat_q   <= lat_d;
      icnt_q  <= icnt_d;
    end
  end

endmodule
